// File: rtl/ship_life_ctl.sv
// Player ship life-cycle controller: ALIVE -> EXPLODE -> RESPAWN/GAME_OVER, timed in frames.
// Frame ticks come from the rising edge of vsync_in; all outputs are registered from the next state.
module ship_life_ctl #(
    parameter int LIVES         = 3,
    parameter int DEAD_FRAMES   = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       hit,
    input  logic       restart,
    output logic [3:0] dead_count,
    output logic       ship_dead,
    output logic       ship_visible,
    output logic       collision_en,
    output logic       game_over,
    output logic [1:0] state
);

    localparam logic [1:0] S_ALIVE   = 2'd0;
    localparam logic [1:0] S_EXPLODE = 2'd1;
    localparam logic [1:0] S_RESPAWN = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    localparam logic [3:0] LIVES_C     = 4'(LIVES);
    localparam logic [7:0] DEAD_LAST   = 8'(DEAD_FRAMES - 1);
    localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

    logic       vs_q;
    logic       vs_q2;
    logic       hit_q;
    logic       arm_q;
    logic       tick;
    logic       hit_rise;
    logic       entry;

    logic [1:0] state_q,        state_d;
    logic [7:0] frame_cnt_q,    frame_cnt_d;
    logic [7:0] blink_cnt_q,    blink_cnt_d;
    logic [3:0] dead_count_q,   dead_count_d;
    logic       ship_dead_q,    ship_dead_d;
    logic       ship_visible_q, ship_visible_d;
    logic       collision_en_q, collision_en_d;
    logic       game_over_q,    game_over_d;

    // arm_q masks the first edge after reset so a hit already high then is not a new hit
    assign tick     = vs_q & ~vs_q2;
    assign hit_rise = hit & ~hit_q & arm_q;

    // Input edge-detect pipeline for vsync and hit
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            hit_q <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            vs_q  <= vsync_in;
            vs_q2 <= vs_q;
            hit_q <= hit;
            arm_q <= 1'b1;
        end
    end

    // Next-state and death-counter logic
    always_comb begin
        state_d      = state_q;
        dead_count_d = dead_count_q;
        case (state_q)
            S_ALIVE: begin
                if (hit_rise) begin
                    state_d      = S_EXPLODE;
                    dead_count_d = (dead_count_q == LIVES_C) ? dead_count_q : dead_count_q + 4'd1;
                end else begin
                    state_d = S_ALIVE;
                end
            end
            S_EXPLODE: begin
                if (tick && (frame_cnt_q == DEAD_LAST)) begin
                    state_d = (dead_count_q == LIVES_C) ? S_OVER : S_RESPAWN;
                end else begin
                    state_d = S_EXPLODE;
                end
            end
            S_RESPAWN: begin
                if (tick && (frame_cnt_q == INVULN_LAST)) begin
                    state_d = S_ALIVE;
                end else begin
                    state_d = S_RESPAWN;
                end
            end
            S_OVER: begin
                if (restart) begin
                    state_d      = S_RESPAWN;
                    dead_count_d = 4'd0;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: begin
                state_d      = S_ALIVE;
                dead_count_d = 4'd0;
            end
        endcase
    end

    // Frame and blink counters restart on every state entry
    always_comb begin
        entry       = (state_d != state_q);
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        if (entry) begin
            frame_cnt_d = 8'd0;
            blink_cnt_d = 8'd0;
        end else if (tick && ((state_q == S_EXPLODE) || (state_q == S_RESPAWN))) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? 8'd0 : blink_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Output decode from the next state
    always_comb begin
        ship_dead_d    = (state_d == S_EXPLODE) || (state_d == S_OVER);
        collision_en_d = (state_d == S_ALIVE);
        game_over_d    = (state_d == S_OVER);
        case (state_d)
            S_ALIVE:   ship_visible_d = 1'b1;
            S_RESPAWN: begin
                if (entry) begin
                    ship_visible_d = 1'b0;
                end else if (tick && (blink_cnt_q == BLINK_LAST)) begin
                    ship_visible_d = ~ship_visible_q;
                end else begin
                    ship_visible_d = ship_visible_q;
                end
            end
            default:   ship_visible_d = 1'b0;
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q        <= S_ALIVE;
            frame_cnt_q    <= 8'd0;
            blink_cnt_q    <= 8'd0;
            dead_count_q   <= 4'd0;
            ship_dead_q    <= 1'b0;
            ship_visible_q <= 1'b1;
            collision_en_q <= 1'b1;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            dead_count_q   <= dead_count_d;
            ship_dead_q    <= ship_dead_d;
            ship_visible_q <= ship_visible_d;
            collision_en_q <= collision_en_d;
            game_over_q    <= game_over_d;
        end
    end

    assign state        = state_q;
    assign dead_count   = dead_count_q;
    assign ship_dead    = ship_dead_q;
    assign ship_visible = ship_visible_q;
    assign collision_en = collision_en_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_ship_life_ctl.sv
// Testbench for ship_life_ctl: directed scenarios plus random traffic, scoreboarded
// against a frame-counting reference model of the ship life rules.
module tb_ship_life_ctl;

    localparam int LIVES         = 3;
    localparam int DEAD_FRAMES   = 2;
    localparam int INVULN_FRAMES = 4;
    localparam int BLINK_FRAMES  = 2;

    logic       pclk     = 1'b0;
    logic       rst      = 1'b1;
    logic       vsync_in = 1'b0;
    logic       hit      = 1'b0;
    logic       restart  = 1'b0;
    logic [3:0] dead_count;
    logic       ship_dead;
    logic       ship_visible;
    logic       collision_en;
    logic       game_over;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    ship_life_ctl #(
        .LIVES(LIVES), .DEAD_FRAMES(DEAD_FRAMES),
        .INVULN_FRAMES(INVULN_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .hit(hit), .restart(restart),
        .dead_count(dead_count), .ship_dead(ship_dead), .ship_visible(ship_visible),
        .collision_en(collision_en), .game_over(game_over), .state(state)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] dc;
        logic       dead;
        logic       vis;
        logic       coll;
        logic       go;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: phase, lives lost, ticks counted in current phase
    int m_phase = 0;
    int m_lost  = 0;
    int m_ticks = 0;
    bit m_vs1 = 1'b0, m_vs2 = 1'b0, m_hp = 1'b0, m_armed = 1'b0;

    function automatic exp_t model_out();
        exp_t o;
        o.st   = 2'(m_phase);
        o.dc   = 4'(m_lost);
        o.dead = (m_phase == 1) || (m_phase == 3);
        o.coll = (m_phase == 0);
        o.go   = (m_phase == 3);
        if (m_phase == 0)      o.vis = 1'b1;
        else if (m_phase == 2) o.vis = (((m_ticks / BLINK_FRAMES) % 2) == 1);
        else                   o.vis = 1'b0;
        return o;
    endfunction

    initial begin
        forever begin
            bit tk;
            bit rise;
            @(posedge pclk or posedge rst);
            if (rst) begin
                m_phase = 0; m_lost = 0; m_ticks = 0;
                m_vs1 = 1'b0; m_vs2 = 1'b0; m_hp = 1'b0; m_armed = 1'b0;
                exp_q.delete();
                exp_q.push_back(model_out());
            end else begin
                tk   = m_vs1 && !m_vs2;
                rise = hit && !m_hp && m_armed;
                case (m_phase)
                    0: if (rise) begin
                        m_lost  = (m_lost + 1 > LIVES) ? LIVES : m_lost + 1;
                        m_phase = 1;
                        m_ticks = 0;
                    end
                    1: if (tk) begin
                        m_ticks++;
                        if (m_ticks == DEAD_FRAMES) begin
                            m_phase = (m_lost == LIVES) ? 3 : 2;
                            m_ticks = 0;
                        end
                    end
                    2: if (tk) begin
                        m_ticks++;
                        if (m_ticks == INVULN_FRAMES) begin
                            m_phase = 0;
                            m_ticks = 0;
                        end
                    end
                    default: if (restart) begin
                        m_lost  = 0;
                        m_phase = 2;
                        m_ticks = 0;
                    end
                endcase
                m_vs2 = m_vs1; m_vs1 = vsync_in; m_hp = hit; m_armed = 1'b1;
                exp_q.push_back(model_out());
            end
        end
    end

    // Monitor: compare every registered output snapshot against the model
    initial begin
        forever begin
            exp_t e;
            exp_t got;
            @(negedge pclk);
            cyc_n++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {state, dead_count, ship_dead, ship_visible, collision_en, game_over};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL scoreboard cyc=%0d got st=%0d dc=%0d dead=%0b vis=%0b coll=%0b go=%0b exp st=%0d dc=%0d dead=%0b vis=%0b coll=%0b go=%0b",
                             cyc_n, got.st, got.dc, got.dead, got.vis, got.coll, got.go,
                             e.st, e.dc, e.dead, e.vis, e.coll, e.go);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic frame();
        vsync_in = 1'b1;
        cyc(1);
        vsync_in = 1'b0;
        cyc(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic hit_pulse();
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
    endtask

    initial begin
        // Reset values, with hit held high across reset release
        hit = 1'b1;
        cyc(3);
        chk("rst_state", int'(state), 0);
        chk("rst_dc", int'(dead_count), 0);
        chk("rst_vis", int'(ship_visible), 1);
        chk("rst_coll", int'(collision_en), 1);
        chk("rst_dead", int'(ship_dead), 0);
        chk("rst_go", int'(game_over), 0);
        rst = 1'b0;
        cyc(4);
        chk("no_rise_after_rst", int'(dead_count), 0);
        chk("no_rise_after_rst_st", int'(state), 0);
        hit = 1'b0;
        cyc(2);

        // Single hit through explode and blinking respawn
        hit_pulse();
        chk("hit_state", int'(state), 1);
        chk("hit_dc", int'(dead_count), 1);
        chk("hit_dead", int'(ship_dead), 1);
        frame();
        chk("explode_1tick", int'(state), 1);
        frame();
        chk("respawn_state", int'(state), 2);
        chk("respawn_coll", int'(collision_en), 0);
        chk("respawn_vis0", int'(ship_visible), 0);
        frame();
        chk("respawn_vis_t1", int'(ship_visible), 0);
        frame();
        chk("respawn_vis_t2", int'(ship_visible), 1);
        frame();
        chk("respawn_t3_state", int'(state), 2);
        frame();
        chk("alive_again", int'(state), 0);
        chk("alive_vis", int'(ship_visible), 1);

        // Held hit counts once; hits in EXPLODE/RESPAWN ignored
        do_reset();
        hit = 1'b1;
        frame(); frame(); frame();
        chk("held_hit_dc", int'(dead_count), 1);
        chk("held_hit_st", int'(state), 2);
        hit = 1'b0;
        cyc(1);
        hit_pulse();
        chk("respawn_hit_dc", int'(dead_count), 1);
        frame(); frame(); frame();
        chk("held_back_alive", int'(state), 0);

        // Three deaths -> game over, then restart
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hit_pulse();
            frame(); frame();
            if (i < 2) begin
                frame(); frame(); frame(); frame();
            end
        end
        chk("go_state", int'(state), 3);
        chk("go_flag", int'(game_over), 1);
        chk("go_dead", int'(ship_dead), 1);
        chk("go_dc", int'(dead_count), 3);
        hit_pulse();
        chk("go_hit_dc", int'(dead_count), 3);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        chk("restart_dc", int'(dead_count), 0);
        chk("restart_st", int'(state), 2);
        chk("restart_go", int'(game_over), 0);
        frame(); frame(); frame(); frame();
        chk("restart_alive", int'(state), 0);

        // Tick and hit_rise in the same ALIVE cycle
        do_reset();
        vsync_in = 1'b1;
        cyc(1);
        vsync_in = 1'b0;
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("tick_hit_st", int'(state), 1);
        cyc(2);
        frame();
        chk("tick_hit_not_counted", int'(state), 1);
        frame();
        chk("tick_hit_respawn", int'(state), 2);

        // Asynchronous reset mid-RESPAWN
        do_reset();
        hit_pulse();
        frame(); frame(); frame(); frame();
        chk("pre_async_st", int'(state), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_st", int'(state), 0);
        chk("async_dc", int'(dead_count), 0);
        chk("async_vis", int'(ship_visible), 1);
        @(negedge pclk);
        rst = 1'b0;
        cyc(2);

        // Random traffic checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            vsync_in = ($urandom_range(0, 5) == 0);
            hit      = ($urandom_range(0, 7) == 0);
            restart  = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0; vsync_in = 1'b0; hit = 1'b0; restart = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
